// File: rtl/factorial_sched_if.sv
// Request/ack/done bundle shared by the two factorial requesters and the engine.
interface factorial_sched_if #(
  parameter int NUM_W = 4,
  parameter int OUT_W = 32
);
  logic             req0;
  logic [NUM_W-1:0] num0;
  logic             req1;
  logic [NUM_W-1:0] num1;
  logic             ack0;
  logic             ack1;
  logic             done0;
  logic             done1;
  logic [OUT_W-1:0] result;
  logic             ovf;
  logic             busy;

  modport master (
    output req0, num0, req1, num1,
    input  ack0, ack1, done0, done1, result, ovf, busy
  );

  modport slave (
    input  req0, num0, req1, num1,
    output ack0, ack1, done0, done1, result, ovf, busy
  );
endinterface

// File: rtl/factorial_sched.sv
// Iterative factorial engine shared by two requesters via a round-robin arbiter.
// One multiply per cycle: counts the operand down to 1, accumulating the product.
module factorial_sched #(
  parameter int NUM_W = 4,
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  factorial_sched_if.slave bus
);
  localparam int P_W = OUT_W + NUM_W;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [NUM_W-1:0] cnt_reg;
  logic [OUT_W-1:0] acc_reg;
  logic [OUT_W-1:0] result_reg;
  logic             ovf_reg;
  logic             owner_reg;
  logic             last_grant_reg;

  logic [1:0]       req;
  logic             grant;
  logic             capture;
  logic [NUM_W-1:0] num_sel;
  logic [P_W-1:0]   prod;
  logic [1:0]       ack;
  logic [1:0]       done;

  assign req = {bus.req1, bus.req0};

  // On a tie the port that was not granted last time wins.
  assign grant   = (&req) ? ~last_grant_reg : req[1];
  assign capture = reset_n && (state_reg == IDLE) && (|req);
  assign num_sel = grant ? bus.num1 : bus.num0;
  assign prod    = {{NUM_W{1'b0}}, acc_reg} * {{OUT_W{1'b0}}, cnt_reg};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = MULT;
      MULT:    if (cnt_reg <= NUM_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      acc_reg        <= '0;
      result_reg     <= '0;
      ovf_reg        <= 1'b0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        cnt_reg        <= num_sel;
        acc_reg        <= OUT_W'(1);
        ovf_reg        <= 1'b0;
        owner_reg      <= grant;
        last_grant_reg <= grant;
      end else if (state_reg == MULT) begin
        if (cnt_reg > NUM_W'(1)) begin
          acc_reg <= prod[OUT_W-1:0];
          ovf_reg <= ovf_reg | (|prod[P_W-1:OUT_W]);
          cnt_reg <= cnt_reg - NUM_W'(1);
        end else begin
          result_reg <= acc_reg;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ack[gi]  = capture && (grant == 1'(gi));
    assign done[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
  end

  assign bus.ack0   = ack[0];
  assign bus.ack1   = ack[1];
  assign bus.done0  = done[0];
  assign bus.done1  = done[1];
  assign bus.result = result_reg;
  assign bus.ovf    = ovf_reg;
  assign bus.busy   = (state_reg != IDLE);
endmodule

// File: tb/tb_factorial_sched.sv
// Scoreboard bench: requests push hand-computed results; a monitor checks each done pulse.
module tb_factorial_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];

  factorial_sched_if #(.NUM_W(4), .OUT_W(32)) ifc ();

  factorial_sched #(.NUM_W(4), .OUT_W(32)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_req(input int port, input logic r, input logic [3:0] n);
    if (port == 0) begin
      ifc.req0 = r;
      ifc.num0 = n;
    end else begin
      ifc.req1 = r;
      ifc.num1 = n;
    end
  endtask

  // Hold req until acked; record the expected completion at the ack cycle.
  task automatic request(input int port, input int n, input logic [31:0] exp_res,
                         input logic exp_ovf, output int ack_cyc);
    exp_t e;
    logic acked = 1'b0;
    ack_cyc = -1;
    set_req(port, 1'b1, 4'(n));
    #1;
    for (int i = 0; i < 300 && !acked; i++) begin
      if ((port == 0) ? ifc.ack0 : ifc.ack1) begin
        acked   = 1'b1;
        ack_cyc = cyc;
        e.port  = port;
        e.res   = exp_res;
        e.ovf   = exp_ovf;
        e.cyc   = cyc + ((n < 1) ? 1 : n) + 1;
        sb.push_back(e);
        grant_log.push_back(port);
      end
      @(posedge clk);
      #1;
    end
    if (!acked) begin
      total++;
      $display("FAIL ack_timeout port=%0d n=%0d: got no ack expected ack", port, n);
    end
    set_req(port, 1'b0, 4'(n));
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_grants(input string name, input int exp_order[$]);
    check({name, "_count"}, grant_log.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
      check($sformatf("%s_%0d", name, i), grant_log[i], exp_order[i]);
    grant_log.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_result"}, ifc.result, 0);
    check({tag, "_ovf"}, ifc.ovf, 0);
    check({tag, "_busy"}, ifc.busy, 0);
    check({tag, "_done"}, {ifc.done1, ifc.done0}, 0);
    check({tag, "_ack"}, {ifc.ack1, ifc.ack0}, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   p;
    if (reset_n && (ifc.done0 || ifc.done1)) begin
      p = ifc.done1 ? 1 : 0;
      $display("done port=%0d result=%0d ovf=%0d cycle=%0d", p, ifc.result, ifc.ovf, cyc);
      if (ifc.done0 && ifc.done1) begin
        total++;
        $display("FAIL both_done: got 2 pulses expected 1");
      end
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done port=%0d: got done expected none", p);
      end else begin
        e = sb.pop_front();
        check("done_port", p, e.port);
        check("result", ifc.result, e.res);
        check("ovf", ifc.ovf, e.ovf);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int a0, a1;
    ifc.req0 = 1'b1;
    ifc.num0 = 4'd3;
    ifc.req1 = 1'b0;
    ifc.num1 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    ifc.req0 = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;

    // single request and edge operands
    request(0, 5, 32'd120, 1'b0, a0);
    drain();
    request(1, 0, 32'd1, 1'b0, a0);
    request(1, 1, 32'd1, 1'b0, a0);
    request(1, 12, 32'd479001600, 1'b0, a0);
    drain();

    // overflow
    request(0, 13, 32'd1932053504, 1'b1, a0);
    request(0, 14, 32'd1278945280, 1'b1, a0);
    request(0, 15, 32'd2004310016, 1'b1, a0);
    drain();

    // tie arbitration starting from reset
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    grant_log.delete();
    fork
      request(0, 3, 32'd6, 1'b0, a0);
      request(1, 4, 32'd24, 1'b0, a1);
    join
    check_grants("tie", '{0, 1});
    fork
      begin
        request(0, 2, 32'd2, 1'b0, a0);
        request(0, 3, 32'd6, 1'b0, a0);
      end
      begin
        request(1, 4, 32'd24, 1'b0, a1);
        request(1, 5, 32'd120, 1'b0, a1);
      end
    join
    check_grants("held", '{0, 1, 0, 1});
    drain();

    // request raised while busy
    request(0, 6, 32'd720, 1'b0, a0);
    @(posedge clk);
    #1;
    ifc.req1 = 1'b1;
    ifc.num1 = 4'd3;
    #1;
    check("busy_ack1", ifc.ack1, 0);
    check("busy_flag", ifc.busy, 1);
    request(1, 3, 32'd6, 1'b0, a1);
    check("busy_ack1_cycle", a1, a0 + 6 + 2);
    drain();

    // reset mid-operation
    request(0, 10, 32'd3628800, 1'b0, a0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    request(0, 4, 32'd24, 1'b0, a0);
    drain();
    check("final_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
